// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared lane types and constants for the AES byte-stream converter
package aes_stream_pkg;

  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } lane_order_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_SHIFT  = 2'd2,
    SEL_APPEND = 2'd3
  } lane_sel_e;

endpackage

// File: rtl/psc_lane_reg.sv
// rtl/psc_lane_reg.sv - one storage lane with hold/load/shift/append next-value select
module psc_lane_reg
  import aes_stream_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  lane_sel_e sel_i,
  input  logic [W-1:0] load_i,
  input  logic [W-1:0] shift_i,
  input  logic [W-1:0] app_i,
  output logic [W-1:0] lane_o
);

  logic [W-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    case (sel_i)
      SEL_HOLD:   lane_d = lane_q;
      SEL_LOAD:   lane_d = load_i;
      SEL_SHIFT:  lane_d = shift_i;
      SEL_APPEND: lane_d = app_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/par_ser_stream_converter.sv
// rtl/par_ser_stream_converter.sv - parallel word to lane stream converter with serial append
module par_ser_stream_converter #(
  parameter int LANE_W    = aes_stream_pkg::LANE_W,
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [LANE_W*NUM_LANES-1:0]   load_data,
  input  logic                          lsb_first,
  input  logic                          app_valid,
  output logic                          app_ready,
  input  logic [LANE_W-1:0]             app_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANE_W-1:0]             out_data,
  output logic                          out_last,
  output logic [CNT_W-1:0]              count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_LANES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  app_idx;
  logic [LANE_W-1:0] lane_q [NUM_LANES];
  logic              load_fire, app_fire, out_fire;
  logic              lsb_order;

  assign out_valid = (count_q != '0);
  assign out_last  = (count_q == ONE);
  assign out_data  = lane_q[0];
  assign count     = count_q;

  // Accepting at count==1 while draining lets the next word follow with no bubble.
  assign load_ready = ~rst & ((count_q == '0) | ((count_q == ONE) & out_ready));
  assign app_ready  = ~rst & ~load_valid & ((count_q < FULL) | out_ready);

  assign out_fire  = out_valid & out_ready;
  assign load_fire = load_valid & load_ready;
  assign app_fire  = app_valid & app_ready;
  assign lsb_order = (lsb_first == aes_stream_pkg::ORDER_LSB_FIRST);

  // Tail slot moves down one when the head leaves in the same cycle.
  assign app_idx = out_fire ? (count_q - ONE) : count_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0]          shift_src;
    logic [LANE_W-1:0]          load_src;
    aes_stream_pkg::lane_sel_e  sel;

    if (i < NUM_LANES - 1) begin : g_mid
      assign shift_src = lane_q[i+1];
    end else begin : g_tail
      assign shift_src = '0;
    end

    assign load_src = lsb_order ? load_data[i*LANE_W +: LANE_W]
                                : load_data[(NUM_LANES-1-i)*LANE_W +: LANE_W];

    always_comb begin
      sel = aes_stream_pkg::SEL_HOLD;
      if (load_fire) begin
        sel = aes_stream_pkg::SEL_LOAD;
      end else if (app_fire && (app_idx == CNT_W'(i))) begin
        sel = aes_stream_pkg::SEL_APPEND;
      end else if (out_fire) begin
        sel = aes_stream_pkg::SEL_SHIFT;
      end
    end

    psc_lane_reg #(
      .W(LANE_W)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .sel_i  (sel),
      .load_i (load_src),
      .shift_i(shift_src),
      .app_i  (app_data),
      .lane_o (lane_q[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (load_fire) begin
      count_d = FULL;
    end else begin
      count_d = count_q - CNT_W'(out_fire) + CNT_W'(app_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_par_ser_stream_converter.sv
// tb/tb_par_ser_stream_converter.sv - self-checking bench for par_ser_stream_converter
module tb_par_ser_stream_converter;

  localparam int NL = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [W*NL-1:0] load_data;
  logic          lsb_first;
  logic          app_valid;
  logic          app_ready;
  logic [W-1:0]  app_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [2:0]    count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] mdl[$];
  logic [W-1:0] emitted[$];

  always #5 clk = ~clk;

  par_ser_stream_converter #(
    .LANE_W   (W),
    .NUM_LANES(NL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .lsb_first (lsb_first),
    .app_valid (app_valid),
    .app_ready (app_ready),
    .app_data  (app_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus: outputs are checked against the queue model, then the
  // model advances by the handshakes the model itself says should fire.
  task automatic cycle(input logic lv, input logic [31:0] ld, input logic lsb,
                       input logic av, input logic [7:0] ad, input logic ordy);
    int   cnt;
    logic exp_lr, exp_ar, ofire;
    load_valid = lv;
    load_data  = ld;
    lsb_first  = lsb;
    app_valid  = av;
    app_data   = ad;
    out_ready  = ordy;
    #1;
    cnt    = mdl.size();
    exp_lr = (cnt == 0) || (cnt == 1 && ordy);
    exp_ar = !lv && (cnt < NL || ordy);
    ofire  = ordy && (cnt != 0);
    check("count", count, cnt);
    check("count_le_max", count <= 3'd4, 1'b1);
    check("out_valid", out_valid, cnt != 0);
    check("out_last", out_last, cnt == 1);
    if (cnt != 0) check("out_data", out_data, mdl[0]);
    check("load_ready", load_ready, exp_lr);
    check("app_ready", app_ready, exp_ar);
    @(posedge clk);
    if (ofire) emitted.push_back(mdl[0]);
    if (lv && exp_lr) begin
      mdl.delete();
      for (int k = 0; k < NL; k++)
        mdl.push_back(lsb ? ld[k*8 +: 8] : ld[(NL-1-k)*8 +: 8]);
    end else begin
      if (ofire) void'(mdl.pop_front());
      if (av && exp_ar) mdl.push_back(ad);
    end
    #1;
  endtask

  task automatic check_emitted(input string tag, input logic [63:0] exp, input int n);
    check({tag, "_len"}, emitted.size(), n);
    for (int j = 0; j < n && j < emitted.size(); j++)
      check(tag, emitted[j], exp[(n-1-j)*8 +: 8]);
    emitted.delete();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, ordy);
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b1; load_data = '0; lsb_first = 1'b0;
    app_valid = 1'b1; app_data = '0; out_ready = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_load_ready", load_ready, 0);
    load_valid = 1'b0;
    #1;
    check("rst_app_ready", app_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    app_valid = 1'b0;

    // Msb-first then lsb-first drain of the same word.
    cycle(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0, 8'h0, 1'b1);
    idle(5, 1'b1);
    check_emitted("msb_first", 64'hA1B2C3D4, 4);
    cycle(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h0, 1'b1);
    idle(5, 1'b1);
    check_emitted("lsb_first", 64'hD4C3B2A1, 4);

    // Back-to-back words with the second load held high.
    cycle(1'b1, 32'h00112233, 1'b0, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h44556677, 1'b0, 1'b0, 8'h0, 1'b1);
    idle(5, 1'b1);
    check_emitted("back_to_back", 64'h0011223344556677, 8);

    // Full with stalled output, then append while the head leaves.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b1);
    check("full_append_count", count, 4);
    idle(5, 1'b1);
    check_emitted("append_full", 64'hDEADBEEF5A, 5);

    // Appends from empty, then a pending load blocks appends until drained.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b1, 32'h10203040, 1'b0, 1'b1, 8'h03, 1'b0);
    cycle(1'b1, 32'h10203040, 1'b0, 1'b1, 8'h03, 1'b0);
    cycle(1'b1, 32'h10203040, 1'b0, 1'b1, 8'h03, 1'b1);
    cycle(1'b1, 32'h10203040, 1'b0, 1'b1, 8'h03, 1'b1);
    idle(5, 1'b1);
    check_emitted("app_then_load", 64'h0102_1020_3040, 6);

    // Asynchronous reset in the middle of a drain.
    cycle(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 8'h0, 1'b1);
    idle(2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_out_data", out_data, 0);
    check("async_load_ready", load_ready, 0);
    mdl.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3, 1'b1);
    check_emitted("after_reset", 64'hCAFE, 2);

    // Randomised traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) == 0, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0);
    end
    emitted.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
